mpc_pipelined_addsub: RTL and testbench
=======================================

Name: mpc_pipelined_addsub

Overview:
- Parametrised, segmented-carry integer adder/subtractor for the MIPS CPU execute stage. It supersedes the fixed 32-bit, two-segment add/sub unit.
- Operand width, segment size (and therefore pipeline depth), signed/unsigned mode and a pass-through tag are all configurable.
- Adds a valid/ready handshake with full-pipeline backpressure, plus carry, overflow and zero flags.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SEG, 16, bits added per pipeline stage. WIDTH % SEG must be 0. NS = WIDTH/SEG is the number of stages (latency).
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- i_valid  in  1  input operation valid.
- o_in_ready  out  1  unit accepts the input this cycle.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_sub  in  1  1 = A-B, 0 = A+B.
- i_signed  in  1  1 = two's-complement overflow rule, 0 = unsigned rule.
- i_tag  in  TAG_W  sideband tag, returned with the result.
- o_valid  out  1  result valid.
- i_out_ready  in  1  consumer accepts the result.
- o_result  out  WIDTH  sum/difference modulo 2^WIDTH.
- o_carry  out  1  carry out of the MSB; for sub, 1 = no borrow.
- o_overflow  out  1  overflow per the mode rule below.
- o_zero  out  1  o_result == 0.
- o_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset: resetn is asynchronous and active-low; clock is clk.
  - While resetn is low, all stage valid bits and all output registers clear: o_valid=0, o_result=0, o_carry=0, o_overflow=0, o_zero=0, o_tag=0.
  - In-flight operations are discarded and never emerge after reset is released.
- Advance enable: adv = ~o_valid | i_out_ready.
  - o_in_ready = adv (combinational; no dependency on i_valid).
  - An input transfer occurs when i_valid & o_in_ready.
  - An output transfer occurs when o_valid & i_out_ready.
- Stall: when adv=0, every stage register, including the outputs, holds its value. Nothing is dropped or duplicated.
- Operand conditioning at input:
  - B' = i_sub ? ~i_b : i_b.
  - Carry-in = i_sub.
- Stage k (k = 0..NS-1):
  - Adds segment k of A and B' using the registered carry from stage k-1 (carry-in for k=0).
  - Registers the partial sum, the carry, and the not-yet-used upper operand segments (skew registers).
  - Sign bits, mode bits and the tag travel with the operation.
  - Bubbles (valid=0) also advance whenever adv=1.
- Latency: an operation accepted on cycle N presents o_valid=1 on cycle N+NS, provided no stall occurs.
  - SEG == WIDTH gives NS=1 (single registered stage).
- Throughput: one operation per cycle when i_out_ready is held high. Results are delivered in strict acceptance order.
- Flags, computed in the final stage:
  - o_carry = carry out of bit WIDTH-1.
  - Unsigned overflow: add -> o_carry==1; sub -> o_carry==0 (borrow).
  - Signed overflow: A[MSB]==B'[MSB] and result[MSB]!=A[MSB].
  - o_overflow selects between the two rules with the operation's registered i_signed.
  - o_zero is 1 exactly when all WIDTH result bits are 0.
- Boundaries:
  - Simultaneous input and output transfer while the pipeline is full is legal; occupancy stays constant.
  - i_valid=0 inserts a bubble.
  - Inputs are ignored (not sampled) when o_in_ready=0.
  - Values on o_result and the flags while o_valid=0 are don't-care for checking, but must not be X after reset.

Test Plan (WIDTH=32, SEG=16, so NS=2):
1. Unsigned add, segment carry crossing: A=0x0000FFFF, B=0x00000001, sub=0, signed=0, accepted at cycle N.
   -> At N+2: o_valid=1, result=0x00010000, carry=0, overflow=0, zero=0.
2. Unsigned wrap: A=0xFFFFFFFF, B=0x00000001, sub=0, signed=0.
   -> result=0x00000000, carry=1, overflow=1, zero=1.
3. Signed add overflow: A=0x7FFFFFFF, B=0x00000001, signed=1.
   -> result=0x80000000, overflow=1, carry=0.
   Same operands with signed=0 -> overflow=0.
4. Subtraction:
   - 0x80000000 - 0x00000001, signed=1 -> result=0x7FFFFFFF, overflow=1, carry=1.
   - 3 - 5, signed=0 -> result=0xFFFFFFFE, carry=0, overflow=1.
   - 5 - 5 -> result=0, zero=1, carry=1, overflow=0.
5. Backpressure ordering: four back-to-back ops with tags 1..4; i_out_ready held low for 3 cycles starting when tag 1 reaches the output.
   -> Tag 1 result held stable, o_in_ready=0 while stalled.
   -> Then tags 1,2,3,4 emerge in order on consecutive cycles with correct results; none lost or duplicated.
6. Reset mid-operation: two ops accepted, resetn pulsed low for one cycle before either completes.
   -> o_valid=0 and all outputs 0 immediately (asynchronous).
   -> No result appears after release.
   -> A new op accepted after release completes with correct latency 2.

Source files
------------

// File: rtl/mpc_pipelined_addsub.sv
// Segmented-carry pipelined adder/subtractor with valid/ready handshake.
// Each stage adds one SEG-bit segment. Operand registers shift right by SEG
// every stage, and each sum segment enters at the top, so after NS stages the
// A register holds the complete result.
module mpc_pipelined_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 16,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    input  logic             i_signed,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero,
    output logic [TAG_W-1:0] o_tag
);

    localparam int unsigned NS = WIDTH / SEG;

    // Stage k registers: state of the operation after segment k is added
    logic             vldR  [NS];
    logic [WIDTH-1:0] aR    [NS];
    logic [WIDTH-1:0] bR    [NS];
    logic             cR    [NS];
    logic             aMsbR [NS];
    logic             bMsbR [NS];
    logic             subR  [NS];
    logic             sgnR  [NS];
    logic [TAG_W-1:0] tagR  [NS];
    logic             ovR;
    logic             zeroR;

    // Next-state values per stage
    logic             nV    [NS];
    logic [WIDTH-1:0] nA    [NS];
    logic [WIDTH-1:0] nB    [NS];
    logic             nC    [NS];
    logic             nAMsb [NS];
    logic             nBMsb [NS];
    logic             nSub  [NS];
    logic             nSgn  [NS];
    logic [TAG_W-1:0] nTag  [NS];
    logic             ovNext;
    logic             zeroNext;

    // Per-stage working values
    logic [WIDTH-1:0] bCond;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             inC;
    logic             inV;
    logic             inAMsb;
    logic             inBMsb;
    logic             inSub;
    logic             inSgn;
    logic [TAG_W-1:0] inTag;
    logic [SEG:0]     segSum;
    logic             adv;

    assign adv        = ~vldR[NS-1] | i_out_ready;
    assign o_in_ready = adv;
    assign bCond      = i_sub ? ~i_b : i_b;

    // Segment adders: stage 0 takes conditioned inputs, later stages the previous registers
    always_comb begin
        inA      = '0;
        inB      = '0;
        inC      = 1'b0;
        inV      = 1'b0;
        inAMsb   = 1'b0;
        inBMsb   = 1'b0;
        inSub    = 1'b0;
        inSgn    = 1'b0;
        inTag    = '0;
        segSum   = '0;
        ovNext   = 1'b0;
        zeroNext = 1'b0;
        for (int k = 0; k < int'(NS); k++) begin
            if (k == 0) begin
                inA    = i_a;
                inB    = bCond;
                inC    = i_sub;
                inV    = i_valid;
                inAMsb = i_a[WIDTH-1];
                inBMsb = bCond[WIDTH-1];
                inSub  = i_sub;
                inSgn  = i_signed;
                inTag  = i_tag;
            end else begin
                inA    = aR[k-1];
                inB    = bR[k-1];
                inC    = cR[k-1];
                inV    = vldR[k-1];
                inAMsb = aMsbR[k-1];
                inBMsb = bMsbR[k-1];
                inSub  = subR[k-1];
                inSgn  = sgnR[k-1];
                inTag  = tagR[k-1];
            end
            segSum   = {1'b0, inA[SEG-1:0]} + {1'b0, inB[SEG-1:0]} + {{SEG{1'b0}}, inC};
            nA[k]    = (inA >> SEG) | (WIDTH'(segSum[SEG-1:0]) << (WIDTH - SEG));
            nB[k]    = inB >> SEG;
            nC[k]    = segSum[SEG];
            nV[k]    = inV;
            nAMsb[k] = inAMsb;
            nBMsb[k] = inBMsb;
            nSub[k]  = inSub;
            nSgn[k]  = inSgn;
            nTag[k]  = inTag;
            if (k == int'(NS) - 1) begin
                // Signed rule: like-signed operands yielding a different sign; unsigned: carry/borrow
                ovNext   = inSgn ? ((inAMsb == inBMsb) && (nA[k][WIDTH-1] != inAMsb))
                                 : (inSub ? ~segSum[SEG] : segSum[SEG]);
                zeroNext = (nA[k] == '0);
            end
        end
    end

    // Pipeline registers, all advancing together whenever the output is free
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < int'(NS); k++) begin
                vldR[k]  <= 1'b0;
                aR[k]    <= '0;
                bR[k]    <= '0;
                cR[k]    <= 1'b0;
                aMsbR[k] <= 1'b0;
                bMsbR[k] <= 1'b0;
                subR[k]  <= 1'b0;
                sgnR[k]  <= 1'b0;
                tagR[k]  <= '0;
            end
            ovR   <= 1'b0;
            zeroR <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < int'(NS); k++) begin
                vldR[k]  <= nV[k];
                aR[k]    <= nA[k];
                bR[k]    <= nB[k];
                cR[k]    <= nC[k];
                aMsbR[k] <= nAMsb[k];
                bMsbR[k] <= nBMsb[k];
                subR[k]  <= nSub[k];
                sgnR[k]  <= nSgn[k];
                tagR[k]  <= nTag[k];
            end
            ovR   <= ovNext;
            zeroR <= zeroNext;
        end
    end

    assign o_valid    = vldR[NS-1];
    assign o_result   = aR[NS-1];
    assign o_carry    = cR[NS-1];
    assign o_overflow = ovR;
    assign o_zero     = zeroR;
    assign o_tag      = tagR[NS-1];

endmodule

// File: tb/tb_mpc_pipelined_addsub.sv
// Scoreboard bench for mpc_pipelined_addsub (WIDTH=32, SEG=16, NS=2).
module tb_mpc_pipelined_addsub;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SEG   = 16;
    localparam int unsigned TAG_W = 4;

    logic             clk = 1'b0;
    logic             resetn;
    logic             i_valid;
    logic             o_in_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_sub;
    logic             i_signed;
    logic [TAG_W-1:0] i_tag;
    logic             o_valid;
    logic             i_out_ready;
    logic [WIDTH-1:0] o_result;
    logic             o_carry;
    logic             o_overflow;
    logic             o_zero;
    logic [TAG_W-1:0] o_tag;

    mpc_pipelined_addsub #(.WIDTH(WIDTH), .SEG(SEG), .TAG_W(TAG_W)) dut (
        .clk(clk), .resetn(resetn), .i_valid(i_valid), .o_in_ready(o_in_ready),
        .i_a(i_a), .i_b(i_b), .i_sub(i_sub), .i_signed(i_signed), .i_tag(i_tag),
        .o_valid(o_valid), .i_out_ready(i_out_ready), .o_result(o_result),
        .o_carry(o_carry), .o_overflow(o_overflow), .o_zero(o_zero), .o_tag(o_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
        logic             z;
        logic [TAG_W-1:0] tag;
        int               acc;
        int               lat;
    } exp_t;

    exp_t sb[$];
    exp_t popE;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: pop and compare on every output transfer
    always @(negedge clk) begin
        if (resetn && o_valid && i_out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got tag %0h expected none", o_tag);
            end else begin
                popE = sb.pop_front();
                chk("result", 64'(o_result), 64'(popE.res));
                chk("carry", 64'(o_carry), 64'(popE.c));
                chk("overflow", 64'(o_overflow), 64'(popE.v));
                chk("zero", 64'(o_zero), 64'(popE.z));
                chk("tag", 64'(o_tag), 64'(popE.tag));
                if (popE.lat != 0) chk("latency", 64'(cyc - popE.acc), 64'(popE.lat));
            end
        end
    end

    // Present one op until accepted; push its expected response on acceptance
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic sgn, input logic [3:0] tag, input logic [31:0] res,
                        input logic c, input logic v, input logic z, input int lat);
        logic rdy;
        logic accepted;
        int   accCyc;
        exp_t e;
        i_a = a; i_b = b; i_sub = sub; i_signed = sgn; i_tag = tag; i_valid = 1'b1;
        accepted = 1'b0;
        for (int n = 0; n < 50 && !accepted; n++) begin
            @(negedge clk);
            rdy    = o_in_ready;
            accCyc = cyc;
            @(posedge clk);
            if (rdy) begin
                accepted = 1'b1;
                e.res = res; e.c = c; e.v = v; e.z = z; e.tag = tag;
                e.acc = accCyc; e.lat = lat;
                sb.push_back(e);
            end
        end
        #1;
        i_valid = 1'b0;
        if (!accepted) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no acceptance expected tag %0h accepted", tag);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge clk);
        #1;
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_valid"}, 64'(o_valid), 64'd0);
        chk({pfx, "_result"}, 64'(o_result), 64'd0);
        chk({pfx, "_carry"}, 64'(o_carry), 64'd0);
        chk({pfx, "_overflow"}, 64'(o_overflow), 64'd0);
        chk({pfx, "_zero"}, 64'(o_zero), 64'd0);
        chk({pfx, "_tag"}, 64'(o_tag), 64'd0);
    endtask

    logic [WIDTH-1:0] heldRes;
    logic             found;

    initial begin
        resetn = 1'b0; i_valid = 1'b0; i_a = '0; i_b = '0; i_sub = 1'b0;
        i_signed = 1'b0; i_tag = '0; i_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        chk("reset_in_ready", 64'(o_in_ready), 64'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors: a, b, sub, signed, tag, result, carry, overflow, zero, latency
        send(32'h0000FFFF, 32'h00000001, 0, 0, 4'h1, 32'h00010000, 0, 0, 0, 2);
        send(32'hFFFFFFFF, 32'h00000001, 0, 0, 4'h2, 32'h00000000, 1, 1, 1, 2);
        send(32'h7FFFFFFF, 32'h00000001, 0, 1, 4'h3, 32'h80000000, 0, 1, 0, 2);
        send(32'h7FFFFFFF, 32'h00000001, 0, 0, 4'h4, 32'h80000000, 0, 0, 0, 2);
        send(32'h80000000, 32'h00000001, 1, 1, 4'h5, 32'h7FFFFFFF, 1, 1, 0, 2);
        send(32'h00000003, 32'h00000005, 1, 0, 4'h6, 32'hFFFFFFFE, 0, 1, 0, 2);
        @(posedge clk);
        #1;
        send(32'h00000005, 32'h00000005, 1, 0, 4'h7, 32'h00000000, 1, 0, 1, 2);
        drain();

        // Backpressure: stall the output for 3 cycles once tag 1 arrives
        fork
            begin
                send(32'h0001FFFF, 32'h00010001, 0, 0, 4'h1, 32'h00030000, 0, 0, 0, 0);
                send(32'hFFFF0000, 32'h00010000, 0, 0, 4'h2, 32'h00000000, 1, 1, 1, 0);
                send(32'h00020000, 32'h00000001, 1, 0, 4'h3, 32'h0001FFFF, 1, 0, 0, 0);
                send(32'h00000000, 32'h80000000, 1, 1, 4'h4, 32'h80000000, 0, 1, 0, 0);
            end
            begin
                found = 1'b0;
                for (int n = 0; n < 30 && !found; n++) begin
                    @(posedge clk);
                    #1;
                    if (o_valid && o_tag == 4'h1) found = 1'b1;
                end
                chk("bp_tag1_arrived", 64'(found), 64'd1);
                i_out_ready = 1'b0;
                heldRes = o_result;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_valid", 64'(o_valid), 64'd1);
                    chk("stall_tag", 64'(o_tag), 64'd1);
                    chk("stall_result", 64'(o_result), 64'(heldRes));
                    chk("stall_in_ready", 64'(o_in_ready), 64'd0);
                    @(posedge clk);
                end
                #1;
                i_out_ready = 1'b1;
                for (int k = 1; k <= 4; k++) begin
                    @(negedge clk);
                    chk("bp_order_valid", 64'(o_valid), 64'd1);
                    chk("bp_order_tag", 64'(o_tag), 64'(k));
                end
            end
        join
        drain();

        // Reset while two ops are in flight, before any output transfer
        send(32'h00001234, 32'h00000001, 0, 0, 4'h8, 32'h00001235, 0, 0, 0, 0);
        send(32'h00005678, 32'h00000001, 0, 0, 4'h9, 32'h00005679, 0, 0, 0, 0);
        #1;
        resetn = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        sb.delete();
        @(negedge clk);
        resetn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_reset_no_valid", 64'(o_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(32'h0000FFFF, 32'h0000FFFF, 0, 0, 4'hA, 32'h0001FFFE, 0, 0, 0, 2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
